riscv_32i: RTL and testbench

//  Fetch/decode front-end of the SwitchMCU RV32I core, controlled by host GPIO registers.
//  - Fetches sequential words from the instruction BRAM (port B).
//  - Holds the fetched word in decode pipeline register pipeReg1.
//  - Decodes pipeReg1 into rd/rs1/rs2/funct3/funct7/opcode/imm.
//  - Raises STOP_sim on EBREAK or when the cycle budget runs out.
//  - Data BRAM port is owned by this block but held idle; the load/store unit is out of scope.

---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/riscv_32i_if.sv | 16 +
 rtl/riscv_decoder.sv | 43 ++++
 rtl/riscv_32i.sv | 159 +++++++++++++++
 tb/tb_riscv_32i.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the SwitchMCU RV32I fetch/decode front-end:
// opcode constants, the EBREAK word, the decoded-field bundle and the FSM states.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [6:0]  opcode;
        logic [31:0] imm;
    } dec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // True for every opcode of the RV32I base instruction set.
    function automatic logic legal_opcode(input logic [6:0] opc);
        logic ok;
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/riscv_32i_if.sv
// Block-RAM port B bundle. The core is the master; the memory is the slave.
interface riscv_32i_if;
    logic        clkb;
    logic        enb;
    logic        rstb;
    logic [3:0]  web;
    logic [31:0] addrb;
    logic [31:0] dinb;
    logic [31:0] doutb;
    logic        rstb_busy;

    modport master (output clkb, enb, rstb, web, addrb, dinb,
                    input  doutb, rstb_busy);
    modport slave  (input  clkb, enb, rstb, web, addrb, dinb,
                    output doutb, rstb_busy);
endinterface

// File: rtl/riscv_decoder.sv
// Combinational RV32I field and immediate extraction.
// With DECODE_TRACE_EN defined, also flags opcodes outside the base set.
module riscv_decoder
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
`ifdef DECODE_TRACE_EN
    output logic        illegal_s,
`endif
    output dec_t        dec
);

    // Raw fields are always extracted; the immediate depends on the format.
    always_comb begin
        dec        = '0;
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = instr[14:12];
        dec.funct7 = instr[31:25];
        dec.opcode = instr[6:0];
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
                dec.imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                dec.imm = {instr[31:12], 12'h000};
            OP_JAL:
                dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                dec.imm = 32'h0000_0000;
        endcase
    end

`ifdef DECODE_TRACE_EN
    // A bubble is not an instruction, so it never counts as illegal.
    assign illegal_s = (instr != 32'h0000_0000) && !legal_opcode(instr[6:0]);
`endif

endmodule

// File: rtl/riscv_32i.sv
// SwitchMCU RV32I fetch/decode front-end, driven by host GPIO registers.
// Sequential fetch from instruction BRAM port B into pipeReg1, combinational
// decode, halt on EBREAK / cycle budget / end PC. Data BRAM port held idle.
// Optional feature macro: DECODE_TRACE_EN (illegal-opcode flag + decode trace).
module riscv_32i
    import riscv_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic             clk,
    input  logic [31:0]      GPIO0_R0_CH1,
    input  logic [31:0]      GPIO0_R0_CH2,
    input  logic [31:0]      GPIO0_R1_CH1,
    input  logic [31:0]      GPIO0_R1_CH2,
    output logic             STOP_sim,
    riscv_32i_if.master      ins_mem,
    riscv_32i_if.master      data_mem
);

    logic              reset_s;
    logic              start_s;
    state_t            state_r;
    logic [XLEN-1:0]   pc_r;
    logic [XLEN-1:0]   fetch_pc_r;
    logic              fetch_vld_r;
    logic [2*XLEN-1:0] pipeReg1;
    logic [31:0]       cycle_cnt_r;
    logic [31:0]       cnt_next_s;
    logic              enable_design;
    logic              stop_r;
    logic              halt_s;
    logic              fetch_s;
    dec_t              dec_s;

    logic [4:0]        rd_stage1;
    logic [4:0]        rs1_stage1;
    logic [4:0]        rs2_stage1;
    logic [2:0]        fun3_stage1;
    logic [6:0]        fun7_stage1;
    logic [6:0]        opcode_stage1;
    logic [31:0]       imm_stage1;

    assign reset_s = GPIO0_R0_CH1[1];
    assign start_s = GPIO0_R0_CH1[0];

    // Halt when the decode stage holds EBREAK, the budget is used up, or fetch passed the end PC.
    always_comb begin
        cnt_next_s = cycle_cnt_r + 32'd1;
        halt_s     = (pipeReg1[31:0] == EBREAK)
                   || ((GPIO0_R1_CH1 != 32'h0) && (cnt_next_s >= GPIO0_R1_CH1))
                   || ((GPIO0_R0_CH2 != 32'h0) && (pc_r >= GPIO0_R0_CH2));
        fetch_s    = (state_r == ST_RUN) && !ins_mem.rstb_busy && !halt_s;
    end

    // Control FSM with PC, fetch tracking, decode register and halt flag.
    always_ff @(posedge clk) begin
        if (reset_s) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            fetch_pc_r    <= RESET_PC;
            fetch_vld_r   <= 1'b0;
            pipeReg1      <= '0;
            cycle_cnt_r   <= 32'h0;
            enable_design <= 1'b0;
            stop_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r       <= ST_RUN;
                        enable_design <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cycle_cnt_r <= cnt_next_s;
                    if (halt_s) begin
                        state_r       <= ST_HALT;
                        stop_r        <= 1'b1;
                        enable_design <= 1'b0;
                        fetch_vld_r   <= 1'b0;
                    end else begin
                        // A cycle without a fetch behind it becomes an all-zero bubble.
                        pipeReg1    <= fetch_vld_r ? {fetch_pc_r, ins_mem.doutb} : '0;
                        fetch_vld_r <= fetch_s;
                        fetch_pc_r  <= pc_r;
                        if (fetch_s) begin
                            pc_r <= pc_r + 32'd4;
                        end
                    end
                end
                ST_HALT: begin
                    stop_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign STOP_sim = stop_r;

    assign ins_mem.clkb  = clk;
    assign ins_mem.enb   = fetch_s;
    assign ins_mem.rstb  = reset_s;
    assign ins_mem.web   = 4'h0;
    assign ins_mem.addrb = pc_r;
    assign ins_mem.dinb  = 32'h0000_0000;

    assign data_mem.clkb  = clk;
    assign data_mem.enb   = 1'b0;
    assign data_mem.rstb  = reset_s;
    assign data_mem.web   = 4'h0;
    assign data_mem.addrb = 32'h0000_0000;
    assign data_mem.dinb  = 32'h0000_0000;

`ifdef DECODE_TRACE_EN
    logic illegal_opcode_s;

    riscv_decoder u_dec (
        .instr     (pipeReg1[31:0]),
        .illegal_s (illegal_opcode_s),
        .dec       (dec_s)
    );
`else
    riscv_decoder u_dec (
        .instr (pipeReg1[31:0]),
        .dec   (dec_s)
    );
`endif

    assign rd_stage1     = dec_s.rd;
    assign rs1_stage1    = dec_s.rs1;
    assign rs2_stage1    = dec_s.rs2;
    assign fun3_stage1   = dec_s.funct3;
    assign fun7_stage1   = dec_s.funct7;
    assign opcode_stage1 = dec_s.opcode;
    assign imm_stage1    = dec_s.imm;

`ifdef DECODE_TRACE_EN
    // Trace every real instruction while it sits in the decode stage.
    always_ff @(posedge clk) begin
        if (!reset_s && (state_r == ST_RUN) && (pipeReg1[31:0] != 32'h0)) begin
            $display("decode pc=%h instr=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h opc=%h imm=%h illegal=%0b",
                     pipeReg1[63:32], pipeReg1[31:0], rd_stage1, rs1_stage1, rs2_stage1,
                     fun3_stage1, fun7_stage1, opcode_stage1, imm_stage1, illegal_opcode_s);
        end
    end
`endif

    // Inputs and decode fields with no consumer inside this block.
    logic unused_s;
    assign unused_s = ^{GPIO0_R0_CH1[31:2], GPIO0_R1_CH2, data_mem.doutb, data_mem.rstb_busy,
                        rd_stage1, rs1_stage1, rs2_stage1, fun3_stage1, fun7_stage1,
                        opcode_stage1, imm_stage1};

endmodule

// File: tb/tb_riscv_32i.sv
// Self-checking bench for riscv_32i: scoreboard of expected decode-stage entries
// checked by a monitor, plus directed reset/start/halt checks.
module tb_riscv_32i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [6:0]  opc;
        logic [31:0] imm;
    } exp_t;

    localparam logic [31:0] EBREAK_W = 32'h0010_0073;

    logic        clk = 1'b0;
    logic [31:0] gpio_r0_ch1 = 32'h0;
    logic [31:0] gpio_r0_ch2 = 32'h0;
    logic [31:0] gpio_r1_ch1 = 32'h0;
    logic [31:0] gpio_r1_ch2 = 32'h0;
    logic        stop_sim;
    logic        busy = 1'b0;
    logic [31:0] imem [0:255];

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    logic mon_on = 1'b0;

    always #5 clk = ~clk;

    riscv_32i_if ins_if ();
    riscv_32i_if data_if ();

    riscv_32i dut (
        .clk          (clk),
        .GPIO0_R0_CH1 (gpio_r0_ch1),
        .GPIO0_R0_CH2 (gpio_r0_ch2),
        .GPIO0_R1_CH1 (gpio_r1_ch1),
        .GPIO0_R1_CH2 (gpio_r1_ch2),
        .STOP_sim     (stop_sim),
        .ins_mem      (ins_if),
        .data_mem     (data_if)
    );

    // Instruction BRAM: one-cycle read latency; data BRAM is idle.
    always @(posedge clk) begin
        if (ins_if.enb) ins_if.doutb <= imem[ins_if.addrb[9:2]];
    end
    assign ins_if.rstb_busy  = busy;
    assign data_if.doutb     = 32'h0;
    assign data_if.rstb_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode computed from the instruction-format rules with integer arithmetic.
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] w);
        exp_t e;
        int   sw;
        sw      = $signed(w);
        e.pc    = pc;
        e.instr = w;
        e.rd    = w[11:7];
        e.rs1   = w[19:15];
        e.rs2   = w[24:20];
        e.f3    = w[14:12];
        e.f7    = w[31:25];
        e.opc   = w[6:0];
        case (w[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: e.imm = 32'(sw >>> 20);
            7'h23: e.imm = 32'((sw >>> 25) * 32 + int'(w[11:7]));
            7'h63: e.imm = 32'((sw >>> 31) * 4096 + int'(w[7]) * 2048
                               + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
            7'h37, 7'h17: e.imm = w & 32'hFFFF_F000;
            7'h6F: e.imm = 32'((sw >>> 31) * 1048576 + int'(w[19:12]) * 4096
                               + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
            default: e.imm = 32'h0;
        endcase
        return e;
    endfunction

    // Monitor: each new non-bubble decode entry is popped from the scoreboard and compared.
    initial begin
        logic [63:0] prev = 64'h0;
        logic        eb_pend = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (eb_pend) begin
                    check("stop_after_ebreak", 64'(stop_sim), 64'h1);
                    eb_pend = 1'b0;
                end
                if (dut.pipeReg1 !== prev && dut.pipeReg1[31:0] !== 32'h0) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_entry", dut.pipeReg1, 64'h0);
                    end else begin
                        e = sb_q.pop_front();
                        check("pipe", dut.pipeReg1, {e.pc, e.instr});
                        check("rd",   64'(dut.rd_stage1),     64'(e.rd));
                        check("rs1",  64'(dut.rs1_stage1),    64'(e.rs1));
                        check("rs2",  64'(dut.rs2_stage1),    64'(e.rs2));
                        check("f3",   64'(dut.fun3_stage1),   64'(e.f3));
                        check("f7",   64'(dut.fun7_stage1),   64'(e.f7));
                        check("opc",  64'(dut.opcode_stage1), 64'(e.opc));
                        check("imm",  64'(dut.imm_stage1),    64'(e.imm));
                    end
                    if (dut.pipeReg1[31:0] == EBREAK_W) eb_pend = 1'b1;
                end
            end
            prev = dut.pipeReg1;
        end
    end

    task automatic do_reset();
        gpio_r0_ch1 = 32'h2;
        @(negedge clk);
        gpio_r0_ch1 = 32'h0;
    endtask

    task automatic do_start();
        gpio_r0_ch1 = 32'h1;
        @(negedge clk);
        gpio_r0_ch1 = 32'h0;
    endtask

    task automatic wait_stop(input string name, input int limit);
        int n = 0;
        while (!stop_sim && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(stop_sim), 64'h1);
    endtask

    initial begin
        logic [31:0] dir_w   [6];
        logic [31:0] dir_imm [5];
        logic [6:0]  opc_tab [11];
        logic [31:0] rnd;
        logic [31:0] model_pc;
        exp_t        e;
        int          cnt;

        dir_w   = '{32'h0050_0093, 32'h0020_A423, 32'hFE00_0EE3, 32'h1234_52B7, 32'h0100_006F, EBREAK_W};
        dir_imm = '{32'h0000_0005, 32'h0000_0008, 32'hFFFF_FFFC, 32'h1234_5000, 32'h0000_0010};
        opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

        // Reset state, BRAM reset pass-through, reset priority over start.
        gpio_r0_ch1 = 32'h2;
        @(negedge clk);
        check("ins_rstb_hi",  64'(ins_if.rstb),  64'h1);
        check("data_rstb_hi", 64'(data_if.rstb), 64'h1);
        gpio_r0_ch1 = 32'h3;
        @(negedge clk);
        gpio_r0_ch1 = 32'h0;
        #1;
        check("ins_rstb_lo",   64'(ins_if.rstb),       64'h0);
        check("rst_enable",    64'(dut.enable_design), 64'h0);
        check("rst_stop",      64'(stop_sim),          64'h0);
        check("rst_pipe",      dut.pipeReg1,           64'h0);
        check("rst_enb",       64'(ins_if.enb),        64'h0);
        check("rst_addrb",     64'(ins_if.addrb),      64'h0);
        check("data_enb",      64'(data_if.enb),       64'h0);
        check("data_web",      64'(data_if.web),       64'h0);
        check("ins_web",       64'(ins_if.web),        64'h0);
        @(negedge clk);

        // Directed decode program ending in EBREAK.
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
        for (int i = 0; i < 6; i++) begin
            imem[i] = dir_w[i];
            e = model(32'(i * 4), dir_w[i]);
            if (i < 5) e.imm = dir_imm[i];
            sb_q.push_back(e);
        end
        mon_on = 1'b1;
        do_start();
        check("start_enable", 64'(dut.enable_design), 64'h1);
        check("first_enb",    64'(ins_if.enb),        64'h1);
        check("first_addrb",  64'(ins_if.addrb),      64'h0);
        @(negedge clk);
        @(negedge clk);
        check("first_pipe", dut.pipeReg1, {32'h0, 32'h0050_0093});
        wait_stop("ebreak_halt", 50);
        repeat (3) @(negedge clk);
        check("halt_frozen", 64'(dut.pipeReg1[31:0]), 64'(EBREAK_W));
        check("halt_enb",    64'(ins_if.enb),          64'h0);
        check("halt_enable", 64'(dut.enable_design),   64'h0);
        do_start();
        @(negedge clk);
        check("halt_ignores_start", 64'(stop_sim), 64'h1);
        check("directed_drained", 64'(sb_q.size()), 64'h0);
        mon_on = 1'b0;

        // Random program with random BRAM busy cycles.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            do begin
                rnd = $urandom();
                rnd[6:0] = opc_tab[$urandom_range(0, 10)];
            end while (rnd == EBREAK_W);
            imem[i] = rnd;
        end
        model_pc = 32'h0;
        mon_on = 1'b1;
        do_start();
        for (int c = 0; c < 150; c++) begin
            busy = ($urandom_range(0, 3) == 0);
            #1;
            check("run_enb",   64'(ins_if.enb),   64'(!busy));
            check("run_addrb", 64'(ins_if.addrb), 64'(model_pc));
            if (!busy) begin
                sb_q.push_back(model(model_pc, imem[model_pc[9:2]]));
                model_pc = model_pc + 32'd4;
            end
            @(negedge clk);
        end
        busy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("busy_enb",    64'(ins_if.enb),           64'h0);
        check("busy_pc",     64'(ins_if.addrb),         64'(model_pc));
        check("busy_bubble", 64'(dut.pipeReg1[31:0]),   64'h0);
        check("random_drained", 64'(sb_q.size()), 64'h0);
        mon_on = 1'b0;
        busy = 1'b0;
        sb_q.delete();

        // Cycle budget of 900 enabled cycles.
        do_reset();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
        gpio_r1_ch1 = 32'h384;
        do_start();
        cnt = 0;
        while (!stop_sim && cnt < 2000) begin
            if (dut.enable_design) cnt++;
            @(negedge clk);
        end
        check("budget_stop",   64'(stop_sim), 64'h1);
        check("budget_cycles", 64'(cnt),      64'd900);
        gpio_r1_ch1 = 32'h0;

        // End-PC limit.
        do_reset();
        gpio_r0_ch2 = 32'h40;
        do_start();
        wait_stop("endpc_stop", 100);
        check("endpc_addrb", 64'(ins_if.addrb), 64'h40);
        gpio_r0_ch2 = 32'h0;

        // Only reset leaves HALT.
        do_reset();
        #1;
        check("reexit_stop",  64'(stop_sim),          64'h0);
        check("reexit_addrb", 64'(ins_if.addrb),      64'h0);
        check("reexit_en",    64'(dut.enable_design), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
